imem_miss_responder: RTL and testbench

//  Memory-side responder for instruction-cache miss traffic. Accepts line-fill requests from the fetch stage,

---
 rtl/imem_miss_responder.sv | 215 +++++++++++++++++++++
 tb/tb_imem_miss_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_miss_responder.sv
// Instruction-cache miss responder: queues line-fill requests in arrival order,
// reads each line from backing memory beat by beat and returns the assembled line.
package imem_miss_pkg;
  localparam int unsigned THR_PER_CORE       = 4;
  localparam int unsigned THR_PER_CORE_WIDTH = 2;
  localparam int unsigned ICACHE_LINE_WIDTH  = 128;
  localparam int unsigned PHY_ADDR_WIDTH     = 32;

  typedef struct packed {
    logic [PHY_ADDR_WIDTH-1:0] addr;
  } memory_request_t;
endpackage

module imem_miss_responder
  import imem_miss_pkg::*;
#(
  parameter int unsigned               QUEUE_DEPTH    = THR_PER_CORE,
  parameter int unsigned               MEM_BEAT_WIDTH = 32,
  parameter logic [PHY_ADDR_WIDTH-1:0] MEM_SIZE_BYTES = 'h10_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid_miss,
  input  memory_request_t               req_info_miss,
  input  logic [THR_PER_CORE_WIDTH-1:0] req_thread_id,
  output logic                          rsp_valid_miss,
  output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
  output logic [ICACHE_LINE_WIDTH-1:0]  rsp_data_miss,
  output logic                          rsp_bus_error,
  output logic                          mem_req_valid,
  output logic [PHY_ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [MEM_BEAT_WIDTH-1:0]     mem_rsp_data,
  input  logic                          mem_rsp_error,
  output logic                          overflow_err
);
  localparam int unsigned NB     = ICACHE_LINE_WIDTH / MEM_BEAT_WIDTH;
  localparam int unsigned BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PA     = PHY_ADDR_WIDTH;
  localparam int unsigned TW     = THR_PER_CORE_WIDTH;
  localparam logic [PA-1:0] LINE_MASK  = ~PA'(ICACHE_LINE_WIDTH / 8 - 1);
  localparam logic [PA-1:0] BEAT_BYTES = PA'(MEM_BEAT_WIDTH / 8);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR, S_RESP} state_e;

  state_e                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [PA-1:0]            base_q, base_d;
  logic [TW-1:0]            tid_q, tid_d;
  logic                     err_q, err_d;
  logic [ICACHE_LINE_WIDTH-1:0] line_q, line_d;
  logic [ICACHE_LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TW-1:0]            rsp_tid_q, rsp_tid_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     overflow_q, overflow_d;
  logic [THR_PER_CORE-1:0]  pending_q, pending_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [PA-1:0]            fifo_addr_q [QUEUE_DEPTH];
  logic [PA-1:0]            fifo_addr_d [QUEUE_DEPTH];
  logic [TW-1:0]            fifo_tid_q  [QUEUE_DEPTH];
  logic [TW-1:0]            fifo_tid_d  [QUEUE_DEPTH];

  logic              push, pop, empty, full;
  logic [PA-1:0]     head_addr, req_base;
  logic [TW-1:0]     head_tid;
  logic [BEAT_W-1:0] req_beat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_tid  = fifo_tid_q[rd_ptr_q];

  // IDLE issues beat 0 in the pop cycle itself, so an in-range fill starts
  // one cycle after the push; ISSUE only covers later beats and stalls.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    tid_d      = tid_q;
    err_d      = err_q;
    line_d     = line_q;
    rsp_data_d = rsp_data_q;
    rsp_tid_d  = rsp_tid_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;
    mem_req_valid = 1'b0;
    req_base   = base_q;
    req_beat   = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          base_d = head_addr;
          tid_d  = head_tid;
          beat_d = '0;
          err_d  = 1'b0;
          if (head_addr >= MEM_SIZE_BYTES) begin
            state_d = S_ERR;
          end else begin
            mem_req_valid = 1'b1;
            req_base      = head_addr;
            req_beat      = '0;
            state_d       = mem_req_ready ? S_WAIT : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          for (int unsigned b = 0; b < NB; b++) begin
            if (beat_q == BEAT_W'(b)) line_d[b*MEM_BEAT_WIDTH +: MEM_BEAT_WIDTH] = mem_rsp_data;
          end
          err_d = err_q | mem_rsp_error;
          if (beat_q == BEAT_W'(NB - 1)) begin
            state_d    = S_RESP;
            rsp_data_d = line_d;
            rsp_tid_d  = tid_q;
            rsp_err_d  = err_d;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_ERR: begin
        err_d     = 1'b1;
        rsp_tid_d = tid_q;
        rsp_err_d = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mem_req_addr = mem_req_valid ? (req_base + PA'(req_beat) * BEAT_BYTES) : '0;
  end

  always_comb begin
    push        = req_valid_miss && !pending_q[req_thread_id] && (!full || pop);
    overflow_d  = overflow_q | (req_valid_miss && !push);
    pending_d   = pending_q;
    fifo_addr_d = fifo_addr_q;
    fifo_tid_d  = fifo_tid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    if (state_q == S_RESP) pending_d[tid_q] = 1'b0;
    if (push) begin
      pending_d[req_thread_id] = 1'b1;
      fifo_addr_d[wr_ptr_q]    = req_info_miss.addr & LINE_MASK;
      fifo_tid_d[wr_ptr_q]     = req_thread_id;
      wr_ptr_d                 = ptr_inc(wr_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      tid_q      <= '0;
      err_q      <= 1'b0;
      line_q     <= '0;
      rsp_data_q <= '0;
      rsp_tid_q  <= '0;
      rsp_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      tid_q      <= tid_d;
      err_q      <= err_d;
      line_q     <= line_d;
      rsp_data_q <= rsp_data_d;
      rsp_tid_q  <= rsp_tid_d;
      rsp_err_q  <= rsp_err_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_tid_q  <= fifo_tid_d;
  end

  assign rsp_valid_miss = (state_q == S_RESP);
  assign rsp_thread_id  = rsp_tid_q;
  assign rsp_data_miss  = rsp_data_q;
  assign rsp_bus_error  = rsp_err_q;
  assign overflow_err   = overflow_q;
endmodule

// File: tb/tb_imem_miss_responder.sv
// Directed bench for imem_miss_responder with a behavioural beat memory
// (configurable ready stall, error beat and stray late beats).
module tb_imem_miss_responder;
  import imem_miss_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid_miss = 1'b0;
  memory_request_t req_info_miss = '0;
  logic [1:0]      req_thread_id = '0;
  logic            rsp_valid_miss;
  logic [1:0]      rsp_thread_id;
  logic [127:0]    rsp_data_miss;
  logic            rsp_bus_error;
  logic            mem_req_valid;
  logic [31:0]     mem_req_addr;
  logic            mem_req_ready = 1'b0;
  logic            mem_rsp_valid = 1'b0;
  logic [31:0]     mem_rsp_data = '0;
  logic            mem_rsp_error = 1'b0;
  logic            overflow_err;

  imem_miss_responder #(
    .QUEUE_DEPTH(4),
    .MEM_BEAT_WIDTH(32),
    .MEM_SIZE_BYTES(32'h10_0000)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid_miss(req_valid_miss), .req_info_miss(req_info_miss), .req_thread_id(req_thread_id),
    .rsp_valid_miss(rsp_valid_miss), .rsp_thread_id(rsp_thread_id), .rsp_data_miss(rsp_data_miss),
    .rsp_bus_error(rsp_bus_error), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_error(mem_rsp_error), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Response monitor
  logic [1:0]   r_tid [$];
  logic [127:0] r_data[$];
  logic         r_err [$];
  int           r_cyc [$];
  initial forever begin
    @(negedge clock);
    if (rsp_valid_miss === 1'b1) begin
      r_tid.push_back(rsp_thread_id);
      r_data.push_back(rsp_data_miss);
      r_err.push_back(rsp_bus_error);
      r_cyc.push_back(cyc);
    end
  end

  // Memory model: word = 0x11111111*(beat+1) ^ {addr[15:8], 24'h0}
  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] b;
    b = 32'(a[3:2]) + 32'd1;
    return (32'h11111111 * b) ^ {a[15:8], 24'h0};
  endfunction

  int          stall = 0;
  int          err_beat = -1;
  bit          stray = 1'b0;
  int          hs_cnt = 0;
  int          vcnt = 0;
  int          unstable = 0;
  logic [31:0] hs_addr[$];
  initial begin : mem_model
    bit          rsp_pend;
    logic [31:0] pend_addr;
    logic [31:0] held;
    int          wcnt;
    rsp_pend = 1'b0; pend_addr = '0; held = '0; wcnt = 0;
    forever begin
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      mem_rsp_error = 1'b0;
      if (rsp_pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word_of(pend_addr);
        mem_rsp_error = (int'(pend_addr[3:2]) == err_beat);
        rsp_pend      = 1'b0;
      end else if (stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        stray         = 1'b0;
      end
      if (mem_req_valid === 1'b1) begin
        vcnt++;
        if (wcnt > 0 && mem_req_addr !== held) unstable++;
        held = mem_req_addr;
        if (wcnt < stall) begin
          mem_req_ready = 1'b0;
          wcnt++;
        end else begin
          mem_req_ready = 1'b1;
          wcnt = 0;
          rsp_pend = 1'b1;
          pend_addr = mem_req_addr;
          hs_cnt++;
          hs_addr.push_back(mem_req_addr);
        end
      end else begin
        mem_req_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] a);
    req_valid_miss     = 1'b1;
    req_thread_id      = t;
    req_info_miss.addr = a;
    tick();
    req_valid_miss = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k;
    k = 0;
    while (r_tid.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (r_tid.size() < n) chk("rsp_timeout", 128'(r_tid.size()), 128'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, t0, h0, v0, k;
    logic [31:0] exp2 [4];
    exp2 = '{32'h40, 32'h44, 32'h48, 32'h4C};

    // 1: reset with stray request
    req_valid_miss = 1'b1; req_thread_id = 2'd3; req_info_miss.addr = 32'h80;
    repeat (3) tick();
    chk("rst_rsp_valid", 128'(rsp_valid_miss), 128'd0);
    chk("rst_rsp_tid", 128'(rsp_thread_id), 128'd0);
    chk("rst_rsp_data", rsp_data_miss, 128'd0);
    chk("rst_bus_err", 128'(rsp_bus_error), 128'd0);
    chk("rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_mem_addr", 128'(mem_req_addr), 128'd0);
    chk("rst_overflow", 128'(overflow_err), 128'd0);
    req_valid_miss = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("post_rst_overflow", 128'(overflow_err), 128'd0);
    chk("post_rst_no_rsp", 128'(r_tid.size()), 128'd0);

    // 2: single fill
    h0 = hs_addr.size();
    t0 = cyc;
    send(2'd2, 32'h40);
    wait_rsp(1, 40);
    chk("t2_latency", 128'(r_cyc[0] - t0), 128'd9);
    chk("t2_data", r_data[0], 128'h44444444_33333333_22222222_11111111);
    chk("t2_tid", 128'(r_tid[0]), 128'd2);
    chk("t2_err", 128'(r_err[0]), 128'd0);
    chk("t2_nbeats", 128'(hs_addr.size() - h0), 128'd4);
    for (int i = 0; i < 4; i++)
      if (h0 + i < hs_addr.size()) chk("t2_beat_addr", 128'(hs_addr[h0+i]), 128'(exp2[i]));
    tick(); tick();
    chk("t2_valid_pulse", 128'(rsp_valid_miss), 128'd0);
    chk("t2_data_hold", rsp_data_miss, 128'h44444444_33333333_22222222_11111111);

    // 3: ordering under backpressure
    stall = 3; unstable = 0;
    n0 = r_tid.size();
    send(2'd0, 32'h100);
    send(2'd1, 32'h200);
    send(2'd3, 32'h30C);
    wait_rsp(n0 + 3, 300);
    chk("t3_tid0", 128'(r_tid[n0]), 128'd0);
    chk("t3_tid1", 128'(r_tid[n0+1]), 128'd1);
    chk("t3_tid2", 128'(r_tid[n0+2]), 128'd3);
    chk("t3_data0", r_data[n0],   128'h45444444_32333333_23222222_10111111);
    chk("t3_data1", r_data[n0+1], 128'h46444444_31333333_20222222_13111111);
    chk("t3_data2", r_data[n0+2], 128'h47444444_30333333_21222222_12111111);
    chk("t3_addr_stable", 128'(unstable), 128'd0);
    stall = 0;

    // 4: out-of-range, last legal line, error beat
    n0 = r_tid.size(); v0 = vcnt; t0 = cyc;
    send(2'd0, 32'h10_0000);
    wait_rsp(n0 + 1, 20);
    chk("t4_oor_latency", 128'(r_cyc[n0] - t0), 128'd3);
    chk("t4_oor_err", 128'(r_err[n0]), 128'd1);
    chk("t4_oor_tid", 128'(r_tid[n0]), 128'd0);
    chk("t4_oor_no_mem", 128'(vcnt - v0), 128'd0);
    n0 = r_tid.size();
    send(2'd1, 32'hF_FFF0);
    wait_rsp(n0 + 1, 40);
    chk("t4_last_err", 128'(r_err[n0]), 128'd0);
    chk("t4_last_data", r_data[n0], 128'hBB444444_CC333333_DD222222_EE111111);
    err_beat = 2;
    n0 = r_tid.size(); h0 = hs_cnt;
    send(2'd2, 32'h40);
    wait_rsp(n0 + 1, 40);
    chk("t4_beat_err", 128'(r_err[n0]), 128'd1);
    chk("t4_beat_err_nbeats", 128'(hs_cnt - h0), 128'd4);
    err_beat = -1;

    // 5: duplicate thread overflow
    chk("t5_ovf_before", 128'(overflow_err), 128'd0);
    n0 = r_tid.size();
    send(2'd1, 32'h80);
    send(2'd1, 32'hC0);
    chk("t5_ovf_set", 128'(overflow_err), 128'd1);
    wait_rsp(n0 + 1, 40);
    repeat (15) tick();
    chk("t5_single_rsp", 128'(r_tid.size() - n0), 128'd1);
    chk("t5_tid", 128'(r_tid[n0]), 128'd1);
    chk("t5_ovf_sticky", 128'(overflow_err), 128'd1);

    // 6: reset while waiting for beat 1
    n0 = r_tid.size(); h0 = hs_cnt; k = 0;
    send(2'd0, 32'h80);
    while (hs_cnt < h0 + 2 && k < 40) begin
      tick();
      k++;
    end
    if (hs_cnt < h0 + 2) chk("t6_beat_timeout", 128'(hs_cnt - h0), 128'd2);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("t6_rst_valid", 128'(rsp_valid_miss), 128'd0);
    chk("t6_rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("t6_rst_ovf", 128'(overflow_err), 128'd0);
    chk("t6_rst_data", rsp_data_miss, 128'd0);
    reset = 1'b1;
    stray = 1'b1;
    repeat (8) tick();
    chk("t6_no_rsp", 128'(r_tid.size() - n0), 128'd0);
    chk("t6_idle", 128'(mem_req_valid), 128'd0);
    t0 = cyc;
    send(2'd2, 32'h40);
    wait_rsp(n0 + 1, 40);
    chk("t6_latency", 128'(r_cyc[n0] - t0), 128'd9);
    chk("t6_data", r_data[n0], 128'h44444444_33333333_22222222_11111111);
    chk("t6_err", 128'(r_err[n0]), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
